// File: rtl/ble_tx_pkg.sv
// Shared constants, FSM encoding and small helpers for the BLE payload transmit chain.
package ble_tx_pkg;

    // CRC-16 generator x^16+x^12+x^5+1
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam int CRC_BITS = 16;

    // Whitening LFSR x^7+x^4+1: width and the feedback tap that is XORed with the output bit
    localparam int WHITEN_W   = 7;
    localparam int WHITEN_TAP = 3;

    // Repetition factor of the rate-1/3 FEC
    localparam int FEC_REPEAT = 3;

    // Default QPSK constellation magnitude
    localparam logic signed [11:0] AMP_DEFAULT = 12'sd1448;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PAYLOAD = 3'd1,
        ST_CRC     = 3'd2,
        ST_PAD     = 3'd3,
        ST_DONE    = 3'd4
    } tx_state_e;

    // One step of the whitening LFSR; the output bit is s[6] before the step
    function automatic logic [WHITEN_W-1:0] whiten_step(input logic [WHITEN_W-1:0] s);
        logic [WHITEN_W-1:0] n;
        n = {s[WHITEN_W-2:0], s[WHITEN_W-1]};
        n[WHITEN_TAP+1] = s[WHITEN_TAP] ^ s[WHITEN_W-1];
        return n;
    endfunction

    // QPSK bit mapping: 0 -> +amp, 1 -> -amp
    function automatic logic signed [11:0] qpsk_map(input logic b, input logic signed [11:0] amp);
        return b ? -amp : amp;
    endfunction

endpackage

// File: rtl/top_transmitter_bt_payload_ble_crc.sv
// Serial CRC-16 generator: seeded at frame start, updated per payload bit,
// then shifted out MSB first while the CRC field is transmitted.
module crc16_gen_ble
    import ble_tx_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic [15:0] seed_i,
    input  logic calc_i,
    input  logic bit_i,
    input  logic shift_i,
    output logic crc_msb_o
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic        fb;

    // Next CRC register value: seed, polynomial update, or plain shift-out
    always_comb begin
        fb    = bit_i ^ crc_q[15];
        crc_d = crc_q;
        if (load_i) begin
            crc_d = seed_i;
        end else if (calc_i) begin
            crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end else if (shift_i) begin
            crc_d = {crc_q[14:0], 1'b0};
        end
    end

    // CRC state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_msb_o = crc_q[15];

endmodule

// File: rtl/top_transmitter_bt_payload_ble.sv
// BLE payload transmitter: payload bits -> optional CRC-16 -> whitening ->
// optional 3x repetition FEC -> QPSK mapper. One coded bit per cycle at most.
module top_transmitter_bt_payload_ble
    import ble_tx_pkg::*;
#(
    parameter logic signed [11:0] AMP = AMP_DEFAULT
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [15:0]        n_bits,
    input  logic [7:0]         UAP,
    input  logic [6:0]         whiten_init,
    input  logic               CRC_enable,
    input  logic               FEC_enable,
    input  logic               data_in,
    input  logic               valid_in,
    output logic               ready_in,
    output logic signed [11:0] data_out_re,
    output logic signed [11:0] data_out_im,
    output logic               valid_out,
    output logic               busy,
    output logic               finished
);

    tx_state_e           state_q;
    logic [15:0]         cnt_q;       // payload bits still to be accepted
    logic [4:0]          crc_cnt_q;   // CRC bits already taken from the generator
    logic [1:0]          rep_q;       // pending repetitions of rep_bit_q
    logic                rep_bit_q;
    logic                fec_q;
    logic                crc_en_q;
    logic [WHITEN_W-1:0] lfsr_q;
    logic                busy_q;
    logic                fin_q;

    logic                half_q;      // first bit of a pair is waiting for its partner
    logic                ibit_q;
    logic signed [11:0]  re_q;
    logic signed [11:0]  im_q;
    logic                vld_q;

    logic in_stream;
    logic new_raw;
    logic new_wbit;
    logic take_new;
    logic seg_last;
    logic emit_vld;
    logic emit_bit;
    logic crc_msb;
    logic frame_start;

    assign frame_start = (state_q == ST_IDLE) && start;

    // Select which coded bit (if any) enters the mapper this cycle
    always_comb begin
        in_stream = (state_q == ST_PAYLOAD) || (state_q == ST_CRC);
        new_raw   = (state_q == ST_CRC) ? crc_msb : data_in;
        new_wbit  = new_raw ^ lfsr_q[WHITEN_W-1];
        take_new  = 1'b0;
        seg_last  = 1'b0;
        if (state_q == ST_PAYLOAD) begin
            take_new = (rep_q == 2'd0) && (cnt_q != 16'd0) && valid_in;
            seg_last = (take_new && !fec_q && (cnt_q == 16'd1)) ||
                       ((rep_q == 2'd1) && (cnt_q == 16'd0));
        end else if (state_q == ST_CRC) begin
            take_new = (rep_q == 2'd0) && (crc_cnt_q != 5'(CRC_BITS));
            seg_last = (take_new && !fec_q && (crc_cnt_q == 5'(CRC_BITS - 1))) ||
                       ((rep_q == 2'd1) && (crc_cnt_q == 5'(CRC_BITS)));
        end
        emit_vld = take_new || (in_stream && (rep_q != 2'd0)) || ((state_q == ST_PAD) && half_q);
        if (take_new) begin
            emit_bit = new_wbit;
        end else if (in_stream && (rep_q != 2'd0)) begin
            emit_bit = rep_bit_q;
        end else begin
            emit_bit = 1'b0;
        end
    end

    // Source may only hand over a bit while the repetition slot is empty
    assign ready_in = (state_q == ST_PAYLOAD) && (rep_q == 2'd0) && (cnt_q != 16'd0);

    crc16_gen_ble u_crc (
        .clk       (clk),
        .rst_n     (reset),
        .load_i    (frame_start),
        .seed_i    ({8'h00, UAP}),
        .calc_i    ((state_q == ST_PAYLOAD) && take_new),
        .bit_i     (data_in),
        .shift_i   ((state_q == ST_CRC) && take_new),
        .crc_msb_o (crc_msb)
    );

    // Frame sequencing, whitening LFSR, FEC repetition and the finished pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            crc_cnt_q <= '0;
            rep_q     <= '0;
            rep_bit_q <= 1'b0;
            fec_q     <= 1'b0;
            crc_en_q  <= 1'b0;
            lfsr_q    <= '0;
            busy_q    <= 1'b0;
            fin_q     <= 1'b0;
        end else begin
            fin_q <= 1'b0;
            if (take_new) begin
                lfsr_q <= whiten_step(lfsr_q);
                if (fec_q) begin
                    rep_q     <= 2'(FEC_REPEAT - 1);
                    rep_bit_q <= new_wbit;
                end
            end else if (in_stream && (rep_q != 2'd0)) begin
                rep_q <= rep_q - 2'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        fec_q     <= FEC_enable;
                        crc_en_q  <= CRC_enable;
                        cnt_q     <= n_bits;
                        lfsr_q    <= whiten_init;
                        crc_cnt_q <= '0;
                        rep_q     <= '0;
                        busy_q    <= 1'b1;
                        if (n_bits != 16'd0) begin
                            state_q <= ST_PAYLOAD;
                        end else if (CRC_enable) begin
                            state_q <= ST_CRC;
                        end else begin
                            // Empty frame: finished follows start directly
                            state_q <= ST_DONE;
                            fin_q   <= 1'b1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (take_new) begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                    if (seg_last) begin
                        state_q <= crc_en_q ? ST_CRC : ST_PAD;
                    end
                end
                ST_CRC: begin
                    if (take_new) begin
                        crc_cnt_q <= crc_cnt_q + 5'd1;
                    end
                    if (seg_last) begin
                        state_q <= ST_PAD;
                    end
                end
                ST_PAD: begin
                    // Without a pad bit the last symbol is on the output now,
                    // so finished must come next cycle rather than after DONE.
                    state_q <= ST_DONE;
                    if (!half_q) begin
                        fin_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    if (!fin_q) begin
                        fin_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // QPSK mapper: pair coded bits into I/Q and present each symbol for one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            half_q <= 1'b0;
            ibit_q <= 1'b0;
            re_q   <= '0;
            im_q   <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            if (frame_start) begin
                half_q <= 1'b0;
            end else if (emit_vld) begin
                if (!half_q) begin
                    ibit_q <= emit_bit;
                    half_q <= 1'b1;
                end else begin
                    re_q   <= qpsk_map(ibit_q, AMP);
                    im_q   <= qpsk_map(emit_bit, AMP);
                    vld_q  <= 1'b1;
                    half_q <= 1'b0;
                end
            end
        end
    end

    assign data_out_re = re_q;
    assign data_out_im = im_q;
    assign valid_out   = vld_q;
    assign busy        = busy_q;
    assign finished    = fin_q;

endmodule

// File: tb/tb_top_transmitter_bt_payload_ble.sv
// Randomized and directed bench for the BLE payload transmitter with a
// queue-based reference model of the coded bit stream.
module tb_top_transmitter_bt_payload_ble;

    localparam int A = 1448;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [15:0]        n_bits;
    logic [7:0]         UAP;
    logic [6:0]         whiten_init;
    logic               CRC_enable;
    logic               FEC_enable;
    logic               data_in;
    logic               valid_in;
    logic               ready_in;
    logic signed [11:0] data_out_re;
    logic signed [11:0] data_out_im;
    logic               valid_out;
    logic               busy;
    logic               finished;

    int n_checks = 0;
    int n_errors = 0;
    int exp_re[$];
    int exp_im[$];

    always #5 clk = ~clk;

    top_transmitter_bt_payload_ble dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .n_bits      (n_bits),
        .UAP         (UAP),
        .whiten_init (whiten_init),
        .CRC_enable  (CRC_enable),
        .FEC_enable  (FEC_enable),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .ready_in    (ready_in),
        .data_out_re (data_out_re),
        .data_out_im (data_out_im),
        .valid_out   (valid_out),
        .busy        (busy),
        .finished    (finished)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_sym(input int re, input int im);
        exp_re.push_back(re);
        exp_im.push_back(im);
    endtask

    // Reference: build the frame bit list, whiten (Galois form of the LFSR), repeat, pad, pair up
    task automatic build_model(input bit pay[$], input bit crc_on, input bit fec_on,
                               input logic [7:0] uap, input logic [6:0] wi);
        bit stream[$];
        bit coded[$];
        int crc;
        int s;
        int w;
        crc = {8'h00, uap};
        s   = wi;
        foreach (pay[i]) begin
            stream.push_back(pay[i]);
            if ((((crc >> 15) & 1) ^ int'(pay[i])) != 0) crc = ((crc << 1) ^ 'h1021) & 'hFFFF;
            else                                          crc = (crc << 1) & 'hFFFF;
        end
        if (crc_on) begin
            for (int k = 15; k >= 0; k--) stream.push_back(crc[k]);
        end
        foreach (stream[i]) begin
            w = (s >> 6) & 1;
            s = ((s << 1) & 'h7F) ^ ((w != 0) ? 'h11 : 'h00);
            for (int r = 0; r < (fec_on ? 3 : 1); r++) coded.push_back(stream[i] ^ w[0]);
        end
        if ((coded.size() % 2) == 1) coded.push_back(1'b0);
        for (int i = 0; i < coded.size(); i += 2) begin
            push_sym(coded[i] ? -A : A, coded[i+1] ? -A : A);
        end
    endtask

    // Drive one frame and check every symbol, the finished timing and the FEC ready gaps
    task automatic run_frame(input bit pay[$], input bit crc_on, input bit fec_on,
                             input logic [7:0] uap, input logic [6:0] wi,
                             input int abort_after, input bit glitch);
        int idx = 0;
        int cyc = 0;
        int got = 0;
        int last_v = -10;
        int acc_cyc = -10;
        int nexp;
        int n;
        bit done = 0;
        nexp = exp_re.size();
        n = pay.size();
        @(negedge clk);
        n_bits = 16'(n); CRC_enable = crc_on; FEC_enable = fec_on;
        UAP = uap; whiten_init = wi; start = 1'b1; valid_in = 1'b0;
        while (!done) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                n_bits = 16'($urandom); UAP = 8'($urandom); whiten_init = 7'($urandom);
                CRC_enable = 1'($urandom); FEC_enable = 1'($urandom);
                check_val("busy_hi", int'(busy), 1);
            end
            if (glitch && cyc == 4) start = 1'b1;
            if (cyc == 5) start = 1'b0;
            if (valid_out) begin
                if (got < nexp) begin
                    check_val($sformatf("sym%0d_re", got), int'(data_out_re), exp_re[got]);
                    check_val($sformatf("sym%0d_im", got), int'(data_out_im), exp_im[got]);
                end else begin
                    check_val("extra_sym", got, nexp - 1);
                end
                got++;
                last_v = cyc;
                if (got == abort_after) begin
                    reset = 1'b0;
                    valid_in = 1'b0;
                    start = 1'b0;
                    #1;
                    check_val("abort_valid", int'(valid_out), 0);
                    check_val("abort_re", int'(data_out_re), 0);
                    check_val("abort_im", int'(data_out_im), 0);
                    check_val("abort_busy", int'(busy), 0);
                    check_val("abort_ready", int'(ready_in), 0);
                    repeat (2) @(negedge clk);
                    reset = 1'b1;
                    for (int k = 0; k < 6; k++) begin
                        @(negedge clk);
                        check_val("abort_no_fin", int'(finished) + int'(busy) + int'(valid_out), 0);
                    end
                    return;
                end
            end
            if (fec_on && (cyc == acc_cyc + 1 || cyc == acc_cyc + 2))
                check_val("fec_ready_gap", int'(ready_in), 0);
            if (finished) begin
                check_val("sym_count", got, nexp);
                check_val("bits_used", idx, n);
                if (nexp > 0) check_val("fin_latency", cyc - last_v, 1);
                else          check_val("fin_empty", cyc, 1);
                done = 1;
            end else if (cyc > 3000) begin
                check_val("timeout", cyc, 0);
                done = 1;
            end
            if (!done) begin
                valid_in = (idx < n) && ($urandom_range(0, 3) != 0);
                data_in  = valid_in ? pay[idx] : 1'($urandom);
                if (ready_in && valid_in) begin
                    idx++;
                    acc_cyc = cyc;
                end
            end
        end
        start = 1'b0;
        valid_in = 1'b0;
        @(negedge clk);
        check_val("busy_lo", int'(busy), 0);
    endtask

    initial begin
        bit pay[$];
        bit crc_on, fec_on;
        logic [7:0] uap;
        logic [6:0] wi;
        int n;

        reset = 1'b0; start = 1'b0; n_bits = '0; UAP = '0; whiten_init = '0;
        CRC_enable = 1'b0; FEC_enable = 1'b0; data_in = 1'b0; valid_in = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_valid", int'(valid_out), 0);
        check_val("rst_re", int'(data_out_re), 0);
        check_val("rst_im", int'(data_out_im), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_fin", int'(finished), 0);
        check_val("rst_ready", int'(ready_in), 0);
        reset = 1'b1;

        // Plain payload, no coding, identity whitening
        pay = '{1, 0, 1, 0, 0, 1, 0, 1};
        exp_re.delete(); exp_im.delete();
        push_sym(-A, A); push_sym(-A, A); push_sym(A, -A); push_sym(A, -A);
        run_frame(pay, 0, 0, 8'h00, 7'h00, -1, 0);

        // FEC on a single bit with pad
        pay = '{1};
        exp_re.delete(); exp_im.delete();
        push_sym(-A, -A); push_sym(-A, A);
        run_frame(pay, 0, 1, 8'h00, 7'h00, -1, 0);

        // All-zero payload with zero CRC seed gives all-zero coded stream
        pay = '{0, 0, 0, 0, 0, 0, 0, 0};
        exp_re.delete(); exp_im.delete();
        repeat (12) push_sym(A, A);
        run_frame(pay, 1, 0, 8'h00, 7'h00, -1, 0);

        // CRC with UAP 0x47
        pay.delete();
        for (int i = 0; i < 8; i++) pay.push_back(1'($urandom));
        exp_re.delete(); exp_im.delete();
        build_model(pay, 1, 0, 8'h47, 7'h00);
        run_frame(pay, 1, 0, 8'h47, 7'h00, -1, 0);

        // Whitening with all-ones seed
        pay = '{0, 0};
        exp_re.delete(); exp_im.delete();
        push_sym(-A, -A);
        run_frame(pay, 0, 0, 8'h00, 7'h7F, -1, 0);

        // Reset after third symbol, then the same frame again
        pay.delete();
        for (int i = 0; i < 20; i++) pay.push_back(1'($urandom));
        exp_re.delete(); exp_im.delete();
        build_model(pay, 0, 0, 8'h5A, 7'h35);
        run_frame(pay, 0, 0, 8'h5A, 7'h35, 3, 0);
        run_frame(pay, 0, 0, 8'h5A, 7'h35, -1, 0);

        // Empty frame, then a frame with a start pulse while busy
        pay.delete();
        exp_re.delete(); exp_im.delete();
        run_frame(pay, 0, 0, 8'h00, 7'h00, -1, 0);
        for (int i = 0; i < 12; i++) pay.push_back(1'($urandom));
        exp_re.delete(); exp_im.delete();
        build_model(pay, 1, 1, 8'hC3, 7'h11);
        run_frame(pay, 1, 1, 8'hC3, 7'h11, -1, 1);

        // CRC only, no payload
        pay.delete();
        exp_re.delete(); exp_im.delete();
        build_model(pay, 1, 0, 8'h9E, 7'h2B);
        run_frame(pay, 1, 0, 8'h9E, 7'h2B, -1, 0);

        // Randomized frames
        for (int f = 0; f < 10; f++) begin
            n = $urandom_range(0, 40);
            crc_on = 1'($urandom); fec_on = 1'($urandom);
            uap = 8'($urandom); wi = 7'($urandom);
            pay.delete();
            for (int i = 0; i < n; i++) pay.push_back(1'($urandom));
            exp_re.delete(); exp_im.delete();
            build_model(pay, crc_on, fec_on, uap, wi);
            run_frame(pay, crc_on, fec_on, uap, wi, -1, (n >= 4) ? 1'($urandom) : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
